// File: rtl/msg_block_buf.sv
// rtl/msg_block_buf.sv - packs the interface byte stream into 64-byte BLAKE2s message blocks
//
// Sits between the I/O interface byte path and the BLAKE2s compression core.
// Incoming bytes are packed little-endian into a block of 16 32-bit words.
// The buffer is zero-cleared when a block is consumed, so the last partial
// block of a message arrives already zero-padded. The cumulative byte count
// t is tracked across the blocks of a message. It restarts after the block
// that carries the last flag.
//
// Optional build macro MSG_BLOCK_BUF_DBL_EN: two banks run in ping-pong.
// Filling continues into the free bank while the other bank waits for the
// core. The block outputs always show the oldest full bank. Without the
// macro a single bank is used, and ready_o is low whenever it is full.
//
// Ports:
//   clk, nreset      clock, synchronous active-low reset
//   data_v_i/data_i  byte valid and byte value from the interface
//   block_first_i    current message is the first block-sequence
//   block_last_i     current bytes belong to the final block
//   ll_i             total message length in bytes
//   ready_o          buffer can accept a byte this cycle
//   blk_v_o          a complete block is held
//   blk_ack_i        compression core has consumed the held block
//   blk_first_o      held block is the first of its message
//   blk_last_o       held block is the final one (f0 flag)
//   t_o              cumulative byte count up to and including the held block
//   rd_idx_i         word index for the read port
//   rd_word_o        word rd_idx_i of the held block (combinational)
//   overflow_o       sticky; a byte arrived while it could not be accepted
module msg_block_buf #(
    parameter int BLOCK_BYTES = 64,
    parameter int T_W         = 64
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           data_v_i,
    input  logic [7:0]     data_i,
    input  logic           block_first_i,
    input  logic           block_last_i,
    input  logic [63:0]    ll_i,
    output logic           ready_o,
    output logic           blk_v_o,
    input  logic           blk_ack_i,
    output logic           blk_first_o,
    output logic           blk_last_o,
    output logic [T_W-1:0] t_o,
    input  logic [3:0]     rd_idx_i,
    output logic [31:0]    rd_word_o,
    output logic           overflow_o
);

    localparam int PTR_W = $clog2(BLOCK_BYTES);

`ifdef MSG_BLOCK_BUF_DBL_EN
    localparam logic DBL = 1'b1;
`else
    localparam logic DBL = 1'b0;
`endif

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Bank 1 is only ever used when DBL is set. Otherwise both bank pointers stay 0.
    state_t           state_q     [2];
    state_t           state_d     [2];
    logic [7:0]       mem_q       [2][BLOCK_BYTES];
    logic [T_W-1:0]   t_q         [2];
    logic             blk_first_q [2];
    logic             blk_last_q  [2];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [T_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             fill_first_q;
    logic             overflow_q;

    logic             wr_free;
    logic             ack_eff;
    logic             recycle;
    logic             accept;
    logic             hit_end;
    logic             hit_last;
    logic             complete;
    logic             first_now;
    logic [T_W-1:0]   cnt_inc;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;

        wr_free = (state_q[wr_bank_q] == FILL);
        ack_eff = blk_ack_i && (state_q[rd_bank_q] == FULL);
        // With two banks, a full write bank means both banks are full and the
        // write bank is the oldest one. A byte may then land in the bank that
        // is being released this very cycle.
        recycle = DBL && ack_eff && !wr_free;
        accept  = data_v_i && (wr_free || recycle);

        cnt_inc   = byte_cnt_q + T_W'(1);
        hit_end   = (wr_ptr_q == {PTR_W{1'b1}});
        hit_last  = block_last_i && (cnt_inc == ll_i);
        complete  = accept && (hit_end || hit_last);
        // A one-byte block has not yet latched its first flag.
        first_now = (wr_ptr_q == '0) ? block_first_i : fill_first_q;

        if (ack_eff) begin
            state_d[rd_bank_q] = FILL;
            rd_bank_d          = DBL ? ~rd_bank_q : 1'b0;
        end

        if (accept) begin
            if (complete) begin
                state_d[wr_bank_q] = FULL;
                wr_ptr_d           = '0;
                byte_cnt_d         = block_last_i ? '0 : cnt_inc;
                wr_bank_d          = DBL ? ~wr_bank_q : 1'b0;
            end else begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                byte_cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b]     <= FILL;
                t_q[b]         <= '0;
                blk_first_q[b] <= 1'b0;
                blk_last_q[b]  <= 1'b0;
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            wr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            fill_first_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
            end
            wr_ptr_q   <= wr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;

            // Clearing the released bank supplies zero padding for the next
            // partial block. A recycled byte written below overrides byte 0.
            if (ack_eff) begin
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    mem_q[rd_bank_q][i] <= '0;
                end
            end

            if (accept) begin
                mem_q[wr_bank_q][wr_ptr_q] <= data_i;
                if (wr_ptr_q == '0) begin
                    fill_first_q <= block_first_i;
                end
                if (complete) begin
                    t_q[wr_bank_q]         <= cnt_inc;
                    blk_first_q[wr_bank_q] <= first_now;
                    blk_last_q[wr_bank_q]  <= block_last_i;
                end
            end

            if (data_v_i && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign ready_o     = wr_free;
    assign blk_v_o     = (state_q[rd_bank_q] == FULL);
    assign t_o         = t_q[rd_bank_q];
    assign blk_first_o = blk_first_q[rd_bank_q];
    assign blk_last_o  = blk_last_q[rd_bank_q];
    assign overflow_o  = overflow_q;
    assign rd_word_o   = {mem_q[rd_bank_q][{rd_idx_i, 2'd3}],
                          mem_q[rd_bank_q][{rd_idx_i, 2'd2}],
                          mem_q[rd_bank_q][{rd_idx_i, 2'd1}],
                          mem_q[rd_bank_q][{rd_idx_i, 2'd0}]};

endmodule

// File: tb/tb_msg_block_buf.sv
// tb/tb_msg_block_buf.sv - self-checking bench for msg_block_buf
module tb_msg_block_buf;

`ifdef MSG_BLOCK_BUF_DBL_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic        data_v_i;
    logic [7:0]  data_i;
    logic        block_first_i;
    logic        block_last_i;
    logic [63:0] ll_i;
    logic        ready_o;
    logic        blk_v_o;
    logic        blk_ack_i;
    logic        blk_first_o;
    logic        blk_last_o;
    logic [63:0] t_o;
    logic [3:0]  rd_idx_i;
    logic [31:0] rd_word_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    msg_block_buf dut (
        .clk           (clk),
        .nreset        (nreset),
        .data_v_i      (data_v_i),
        .data_i        (data_i),
        .block_first_i (block_first_i),
        .block_last_i  (block_last_i),
        .ll_i          (ll_i),
        .ready_o       (ready_o),
        .blk_v_o       (blk_v_o),
        .blk_ack_i     (blk_ack_i),
        .blk_first_o   (blk_first_o),
        .blk_last_o    (blk_last_o),
        .t_o           (t_o),
        .rd_idx_i      (rd_idx_i),
        .rd_word_o     (rd_word_o),
        .overflow_o    (overflow_o)
    );

    // Reference model: a message is a byte sequence cut into 64-byte pieces.
    // The final piece is zero-padded. Each finished piece is queued with its
    // running length and flags.
    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  t;
        logic         first;
        logic         last;
    } blk_t;

    blk_t         exp_q[$];
    logic [511:0] m_data;
    int           m_ptr;
    logic [63:0]  m_cnt;
    logic         m_first;
    int           errors = 0;
    int           checks = 0;

    task automatic model_reset();
        m_data  = '0;
        m_ptr   = 0;
        m_cnt   = '0;
        m_first = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b, input logic first, input logic last);
        blk_t e;
        if (m_ptr == 0) m_first = first;
        m_data[8*m_ptr +: 8] = b;
        m_ptr++;
        m_cnt++;
        if (m_ptr == 64 || (last && m_cnt == ll_i)) begin
            e.data  = m_data;
            e.t     = m_cnt;
            e.first = m_first;
            e.last  = last;
            exp_q.push_back(e);
            m_data = '0;
            m_ptr  = 0;
            if (last) m_cnt = '0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b, input logic first, input logic last);
        logic exp_v;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_byte got %0b exp 1", ready_o);
        end
        data_v_i      = 1'b1;
        data_i        = b;
        block_first_i = first;
        block_last_i  = last;
        @(negedge clk);
        data_v_i      = 1'b0;
        block_first_i = 1'b0;
        block_last_i  = 1'b0;
        push_byte(b, first, last);
        exp_v = (exp_q.size() != 0);
        checks++;
        if (blk_v_o !== exp_v) begin
            errors++;
            $display("FAIL blk_v_after_byte got %0b exp %0b", blk_v_o, exp_v);
        end
    endtask

    task automatic check_front(input string tag);
        blk_t e;
        e = exp_q[0];
        checks++;
        if (blk_v_o !== 1'b1) begin
            errors++;
            $display("FAIL %s blk_v_o got %0b exp 1", tag, blk_v_o);
        end
        checks++;
        if (t_o !== e.t) begin
            errors++;
            $display("FAIL %s t_o got %0d exp %0d", tag, t_o, e.t);
        end
        checks++;
        if (blk_first_o !== e.first) begin
            errors++;
            $display("FAIL %s blk_first_o got %0b exp %0b", tag, blk_first_o, e.first);
        end
        checks++;
        if (blk_last_o !== e.last) begin
            errors++;
            $display("FAIL %s blk_last_o got %0b exp %0b", tag, blk_last_o, e.last);
        end
        for (int i = 0; i < 16; i++) begin
            rd_idx_i = 4'(i);
            #1;
            checks++;
            if (rd_word_o !== e.data[32*i +: 32]) begin
                errors++;
                $display("FAIL %s rd_word[%0d] got %08h exp %08h", tag, i, rd_word_o, e.data[32*i +: 32]);
            end
        end
        @(negedge clk);
    endtask

    task automatic ack_front();
        logic exp_v;
        blk_ack_i = 1'b1;
        @(negedge clk);
        blk_ack_i = 1'b0;
        void'(exp_q.pop_front());
        exp_v = (exp_q.size() != 0);
        checks++;
        if (blk_v_o !== exp_v) begin
            errors++;
            $display("FAIL ack blk_v_o got %0b exp %0b", blk_v_o, exp_v);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ack ready_o got %0b exp 1", ready_o);
        end
    endtask

    task automatic send_seq(input int n, input int base, input bit rnd, input logic first,
                            input int last_from, input bit auto_chk);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            if (rnd && $urandom_range(0, 3) == 0) @(negedge clk);
            b = rnd ? 8'($urandom) : 8'(base + k);
            send_byte(b, first, (k >= last_from));
            if (auto_chk && exp_q.size() != 0) begin
                check_front("auto");
                ack_front();
            end
        end
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        model_reset();
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (blk_v_o !== 1'b0) begin errors++; $display("FAIL %s blk_v_o got %0b exp 0", tag, blk_v_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL %s ready_o got %0b exp 1", tag, ready_o); end
        checks++;
        if (t_o !== 64'd0) begin errors++; $display("FAIL %s t_o got %0d exp 0", tag, t_o); end
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL %s overflow_o got %0b exp 0", tag, overflow_o); end
        checks++;
        if ({blk_first_o, blk_last_o} !== 2'b00) begin
            errors++;
            $display("FAIL %s first/last got %0b%0b exp 00", tag, blk_first_o, blk_last_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle("reset");
    endtask

    task automatic test_full_blocks();
        logic exp_rdy;
        exp_rdy = DBL;
        ll_i = 64'd200;
        send_seq(64, 0, 1'b0, 1'b1, 999, 1'b0);
        rd_idx_i = 4'd0;
        #1;
        checks++;
        if (rd_word_o !== 32'h03020100) begin errors++; $display("FAIL blk1 word0 got %08h exp 03020100", rd_word_o); end
        rd_idx_i = 4'd15;
        #1;
        checks++;
        if (rd_word_o !== 32'h3F3E3D3C) begin errors++; $display("FAIL blk1 word15 got %08h exp 3f3e3d3c", rd_word_o); end
        checks++;
        if (t_o !== 64'd64) begin errors++; $display("FAIL blk1 t_o got %0d exp 64", t_o); end
        checks++;
        if (ready_o !== exp_rdy) begin errors++; $display("FAIL blk1 ready_o got %0b exp %0b", ready_o, exp_rdy); end
        @(negedge clk);
        check_front("blk1");
        ack_front();
        send_seq(64, 64, 1'b0, 1'b0, 999, 1'b1);
        send_seq(72, 0, 1'b1, 1'b0, 64, 1'b1);
    endtask

    task automatic test_padding();
        logic [7:0] pb [3];
        pb[0] = 8'hAA;
        pb[1] = 8'hBB;
        pb[2] = 8'hCC;
        ll_i = 64'd3;
        for (int k = 0; k < 3; k++) send_byte(pb[k], 1'b1, 1'b1);
        rd_idx_i = 4'd0;
        #1;
        checks++;
        if (rd_word_o !== 32'h00CCBBAA) begin errors++; $display("FAIL pad word0 got %08h exp 00ccbbaa", rd_word_o); end
        checks++;
        if (t_o !== 64'd3 || blk_last_o !== 1'b1) begin
            errors++;
            $display("FAIL pad t/last got %0d/%0b exp 3/1", t_o, blk_last_o);
        end
        @(negedge clk);
        check_front("pad");
        ack_front();
    endtask

    task automatic test_random_msgs();
        int lens [6];
        lens[0] = 1;
        lens[1] = 64;
        lens[2] = 65;
        lens[3] = 128;
        lens[4] = $urandom_range(2, 200);
        lens[5] = $urandom_range(2, 200);
        for (int m = 0; m < 6; m++) begin
            ll_i = 64'(lens[m]);
            send_seq(lens[m], 0, 1'b1, 1'($urandom_range(0, 1)), ((lens[m] - 1) / 64) * 64, 1'b1);
        end
    endtask

    task automatic test_overflow();
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0b exp 0", overflow_o); end
        ll_i = 64'd200;
        send_seq(64, 0, 1'b1, 1'b1, 999, 1'b0);
        if (!DBL) begin
            check_front("ovf_blk");
            data_v_i  = 1'b1;
            data_i    = 8'h5A;
            blk_ack_i = 1'b1;
            @(negedge clk);
            data_v_i  = 1'b0;
            blk_ack_i = 1'b0;
            void'(exp_q.pop_front());
            checks++;
            if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow_o); end
            checks++;
            if (blk_v_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL ovf_state v/rdy got %0b/%0b exp 0/1", blk_v_o, ready_o);
            end
            send_seq(64, 0, 1'b1, 1'b0, 999, 1'b1);
            checks++;
            if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow_o); end
        end
    endtask

    task automatic test_reset_mid();
        ll_i = 64'd200;
        send_seq(10, 0, 1'b1, 1'b1, 999, 1'b1);
        do_reset();
        check_idle("reset_mid");
        send_seq(64, 0, 1'b1, 1'b1, 999, 1'b1);
    endtask

`ifdef MSG_BLOCK_BUF_DBL_EN
    task automatic test_dbl();
        do_reset();
        ll_i = 64'd200;
        send_seq(128, 0, 1'b1, 1'b1, 999, 1'b0);
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL dbl_full ready_o got %0b exp 0", ready_o); end
        check_front("dbl_a");
        data_v_i      = 1'b1;
        data_i        = 8'hE7;
        block_first_i = 1'b0;
        blk_ack_i     = 1'b1;
        @(negedge clk);
        data_v_i  = 1'b0;
        blk_ack_i = 1'b0;
        void'(exp_q.pop_front());
        push_byte(8'hE7, 1'b0, 1'b0);
        checks++;
        if (overflow_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL dbl_recycle ovf/rdy got %0b/%0b exp 0/1", overflow_o, ready_o);
        end
        check_front("dbl_b");
        ack_front();
        send_seq(63, 0, 1'b1, 1'b0, 999, 1'b1);
    endtask
`endif

    initial begin
        nreset        = 1'b0;
        data_v_i      = 1'b0;
        data_i        = 8'h00;
        block_first_i = 1'b0;
        block_last_i  = 1'b0;
        ll_i          = 64'd200;
        blk_ack_i     = 1'b0;
        rd_idx_i      = 4'd0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_full_blocks();
        test_padding();
        test_random_msgs();
        test_overflow();
        test_reset_mid();
`ifdef MSG_BLOCK_BUF_DBL_EN
        test_dbl();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
